lct_quality_sched: RTL and testbench
====================================

# lct_quality_sched

Round-robin scheduler that shares a single combinational LCT quality encoder between two candidate requesters (first- and second-LCT builders). Grants one candidate at a time and drives the encoder inputs from registers. Captures the 4-bit quality one cycle later and presents it, with the candidate key and source id, on a valid/ready output port. Sits between the ALCT-CLCT match logic and the LCT sort/MPC output stage.

## Interface
- KEYW, default 8, width of the candidate key payload carried alongside the quality.
- clock  in  1  main 40 MHz TMB clock; all logic is on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0, req1  in  1  candidate request from requester 0 or 1.
- ack0, ack1  out  1  one-cycle grant/accept pulse to requester 0 or 1.
- cand0_flags, cand1_flags  in  6  {ACC, A, C, A4, C4, CPAT}.
- cand0_pat, cand1_pat  in  4  CLCT pattern number.
- cand0_key, cand1_key  in  KEYW  opaque candidate key.
- enc_flags  out  6  registered flags to the shared encoder.
- enc_pat  out  4  registered pattern to the shared encoder.
- enc_q  in  4  encoder quality; combinational from enc_flags/enc_pat.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_q  out  4  captured quality.
- out_key  out  KEYW  key of the evaluated candidate.
- out_src  out  1  requester index of the evaluated candidate.
- busy  out  1  high in any state other than IDLE.
- err_clr  in  1  clears err_cnt (see Configuration).
- err_cnt  out  8  count of evaluations returning Q=0.

## Operation
- FSM states: IDLE, EVAL, HOLD.
- IDLE, no req: stays in IDLE.
- IDLE, any req high:
  - Select the winner.
  - Load enc_flags, enc_pat, the key and src registers from the winner.
  - Pulse the winner's ack.
  - Go to EVAL.
- Winner selection:
  - Only one req high: that requester wins.
  - Both req high: the requester not granted last wins (round-robin).
  - The last-grant register resets to 1, so requester 0 wins the first tie.
- EVAL: capture enc_q into out_q, set out_valid, go to HOLD.
- HOLD: hold out_valid and all out_* stable until out_ready=1. On that edge, clear out_valid and go to IDLE.
- A req is never granted from EVAL or HOLD. Requests stay pending and are arbitrated on return to IDLE.
- Requester rule:
  - Hold req and the cand* fields stable until ack is seen.
  - On the cycle after ack, either drop req or present the next candidate.
  - The block never samples cand* except on the grant edge.
- enc_flags and enc_pat hold their last value between grants; they are not cleared after a grant.
- out_key and out_src hold their last value after the handshake.
- Simultaneous out_ready and a pending req in HOLD: the handshake completes, and the grant occurs on the following IDLE cycle.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - state IDLE, last-grant register = 1;
  - ack0, ack1, out_valid, busy = 0;
  - enc_flags, enc_pat, out_q, out_key, out_src, err_cnt = 0.
- Reset mid-operation discards the in-flight candidate without an output. A candidate already acked is lost, and its requester must resubmit.
- With req sampled high in IDLE at edge k:
  - ack is high during cycle k..k+1;
  - enc_* are valid from edge k;
  - out_valid rises at edge k+1.
- Latency: req to out_valid = 2 clocks.
- Throughput: one result per 3 clocks when out_ready is tied high.
- out_valid is never asserted on the same edge as an ack.
- At most one ack is high in any cycle.

## Configuration
- Macro LCT_QSCHED_ERRCNT_EN.
- Defined:
  - err_cnt increments in EVAL when enc_q==0.
  - err_cnt saturates at 255.
  - err_clr=1 forces it to 0 on the next edge, and has priority over an increment on the same edge.
- Undefined: err_cnt is tied to 0, err_clr is ignored, and no counter logic is synthesized.

## Test plan
- Single request: req0 with flags {0,1,1,1,1,1}, pat=10, key=0x5A, enc model computing quality; out_ready=1. Required: ack0 at edge k, out_valid at k+1 with out_q=15, out_key=0x5A, out_src=0.
- Tie after reset: req0 and req1 held high together, out_ready=1. Required: grants alternate 0,1,0,1, one grant per 3 clocks, never both acks in the same cycle.
- Backpressure: out_ready=0 for 10 cycles after out_valid. Required: out_valid and out_q/out_key stable throughout, no ack during HOLD, IDLE one clock after out_ready=1.
- Reset mid-operation: reset_n low in EVAL. Required: out_valid never asserts for that candidate, all outputs 0 after the reset edge, and the next grant goes to requester 0 on a tie.
- Error counter (macro defined): 300 candidates with flags all 0 (enc_q=0). Required: err_cnt saturates at 255; err_clr pulse returns it to 0. With the macro undefined, err_cnt stays 0.

Source files
------------

// File: rtl/lct_quality_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lct_quality_sched_if : requester, shared-encoder and result-port bundle
// Rev 1.0
// ---------------------------------------------------------------------------
interface lct_quality_sched_if #(
    parameter int KEYW = 8
);
    logic            req0;
    logic            req1;
    logic            ack0;
    logic            ack1;
    logic [5:0]      cand0_flags;
    logic [5:0]      cand1_flags;
    logic [3:0]      cand0_pat;
    logic [3:0]      cand1_pat;
    logic [KEYW-1:0] cand0_key;
    logic [KEYW-1:0] cand1_key;
    logic [5:0]      enc_flags;
    logic [3:0]      enc_pat;
    logic [3:0]      enc_q;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_q;
    logic [KEYW-1:0] out_key;
    logic            out_src;
    logic            busy;
    logic            err_clr;
    logic [7:0]      err_cnt;

    // master: requesters, encoder and downstream; slave: the scheduler
    modport master (
        output req0, req1, cand0_flags, cand1_flags, cand0_pat, cand1_pat,
               cand0_key, cand1_key, enc_q, out_ready, err_clr,
        input  ack0, ack1, enc_flags, enc_pat, out_valid, out_q, out_key,
               out_src, busy, err_cnt
    );
    modport slave (
        input  req0, req1, cand0_flags, cand1_flags, cand0_pat, cand1_pat,
               cand0_key, cand1_key, enc_q, out_ready, err_clr,
        output ack0, ack1, enc_flags, enc_pat, out_valid, out_q, out_key,
               out_src, busy, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/lct_quality_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lct_quality_sched : round-robin share of one LCT quality encoder between two
// requesters. Optional Q=0 counter enabled by LCT_QSCHED_ERRCNT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
module lct_quality_sched #(
    parameter int KEYW = 8
) (
    input  wire logic           clock,
    input  wire logic           reset_n,
    lct_quality_sched_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVAL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]      r_state;
    logic            r_last;
    logic            r_ack0;
    logic            r_ack1;
    logic [5:0]      r_enc_flags;
    logic [3:0]      r_enc_pat;
    logic [3:0]      r_out_q;
    logic [KEYW-1:0] r_out_key;
    logic            r_out_src;
    logic            r_out_valid;

    logic w_any;
    logic w_win;

    assign w_any = bus.req0 | bus.req1;
    // On a tie the requester not granted last wins; otherwise whoever asks.
    assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 1'b1;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_enc_flags <= '0;
            r_enc_pat   <= '0;
            r_out_q     <= '0;
            r_out_key   <= '0;
            r_out_src   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ack0      <= ~w_win;
                        r_ack1      <= w_win;
                        r_last      <= w_win;
                        r_enc_flags <= w_win ? bus.cand1_flags : bus.cand0_flags;
                        r_enc_pat   <= w_win ? bus.cand1_pat   : bus.cand0_pat;
                        r_out_key   <= w_win ? bus.cand1_key   : bus.cand0_key;
                        r_out_src   <= w_win;
                        r_state     <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_out_q     <= bus.enc_q;
                    r_out_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef LCT_QSCHED_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_eval_zero;

    assign w_eval_zero = (r_state == S_EVAL) && (bus.enc_q == 4'd0);

    // Clear wins over a same-edge increment; the count saturates at 255.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_err_cnt <= '0;
        end else if (bus.err_clr) begin
            r_err_cnt <= '0;
        end else if (w_eval_zero && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign bus.err_cnt = r_err_cnt;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.enc_flags = r_enc_flags;
    assign bus.enc_pat   = r_enc_pat;
    assign bus.out_valid = r_out_valid;
    assign bus.out_q     = r_out_q;
    assign bus.out_key   = r_out_key;
    assign bus.out_src   = r_out_src;
    assign bus.busy      = (r_state != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_lct_quality_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lct_quality_sched : directed + randomized bench with a transaction-level
// reference model of the scheduler.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_lct_quality_sched;
    localparam int KEYW = 8;

    logic clock = 1'b0;
    logic reset_n;

    lct_quality_sched_if #(.KEYW(KEYW)) bus ();
    lct_quality_sched #(.KEYW(KEYW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    always #5 clock = ~clock;

    // Stand-in for the shared quality encoder; flags = {ACC,A,C,A4,C4,CPAT}
    function automatic logic [3:0] enc_q_fn(input logic [5:0] f, input logic [3:0] p);
        if (f[4:3] == 2'b00) return 4'd0;
        if (f[5]) return 4'd1;
        if (f[4:0] == 5'h1F && p >= 4'd10) return 4'd15;
        return 4'(2 + int'(f[2]) + int'(f[1]) + int'(f[0]) + int'(p[1:0]));
    endfunction

    bit              d_req [2];
    logic [5:0]      d_flags [2];
    logic [3:0]      d_pat [2];
    logic [KEYW-1:0] d_key [2];
    logic            d_ready;
    logic            d_clr;

    assign bus.req0        = d_req[0];
    assign bus.req1        = d_req[1];
    assign bus.cand0_flags = d_flags[0];
    assign bus.cand1_flags = d_flags[1];
    assign bus.cand0_pat   = d_pat[0];
    assign bus.cand1_pat   = d_pat[1];
    assign bus.cand0_key   = d_key[0];
    assign bus.cand1_key   = d_key[1];
    assign bus.out_ready   = d_ready;
    assign bus.err_clr     = d_clr;
    assign bus.enc_q       = enc_q_fn(bus.enc_flags, bus.enc_pat);

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one transaction in flight, described by its grant edge.
    int              m_edge = 0;
    bit              m_active;
    int              m_gedge;
    bit              m_last;
    bit              m_src;
    logic [KEYW-1:0] m_key;
    logic [5:0]      m_flags;
    logic [3:0]      m_pat;
    logic [3:0]      m_q;
    bit              m_valid;
    int              m_err;
    bit              m_ack [2];

    task automatic model_reset();
        m_active = 0; m_last = 1; m_src = 0; m_key = '0; m_flags = '0;
        m_pat = '0; m_q = '0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_edge();
        bit was;
        bit eval;
        bit w;
        m_edge++;
        m_ack[0] = 0;
        m_ack[1] = 0;
        if (!reset_n) begin
            model_reset();
            return;
        end
        was  = m_active;
        eval = m_active && (m_edge == m_gedge + 1);
`ifdef LCT_QSCHED_ERRCNT_EN
        if (d_clr) m_err = 0;
        else if (eval && enc_q_fn(m_flags, m_pat) == 4'd0 && m_err < 255) m_err++;
`endif
        if (eval) begin
            m_q = enc_q_fn(m_flags, m_pat);
            m_valid = 1;
        end else if (m_valid && d_ready) begin
            m_active = 0;
            m_valid = 0;
        end
        if (!was && (d_req[0] || d_req[1])) begin
            w = (d_req[0] && d_req[1]) ? !m_last : d_req[1];
            m_active = 1; m_gedge = m_edge; m_last = w; m_src = w;
            m_key = d_key[w]; m_flags = d_flags[w]; m_pat = d_pat[w];
            m_ack[w] = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("ack0",      bus.ack0,      m_ack[0]);
        chk("ack1",      bus.ack1,      m_ack[1]);
        chk("enc_flags", bus.enc_flags, m_flags);
        chk("enc_pat",   bus.enc_pat,   m_pat);
        chk("out_valid", bus.out_valid, m_valid);
        chk("out_q",     bus.out_q,     m_q);
        chk("out_key",   bus.out_key,   m_key);
        chk("out_src",   bus.out_src,   m_src);
        chk("busy",      bus.busy,      m_active);
        chk("err_cnt",   bus.err_cnt,   m_err);
    endtask

    task automatic cycle();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_all();
    endtask

    // Requesters keep a request and its candidate until acked, then re-roll.
    task automatic rand_inputs(input int p_req, input int p_ready, input int p_clr);
        for (int i = 0; i < 2; i++) begin
            if (!(d_req[i] && !m_ack[i])) begin
                d_req[i] = ($urandom_range(99) < p_req);
                if (d_req[i]) begin
                    d_flags[i] = 6'($urandom);
                    d_pat[i]   = 4'($urandom);
                    d_key[i]   = KEYW'($urandom);
                end
            end
        end
        d_ready = ($urandom_range(99) < p_ready);
        d_clr   = ($urandom_range(99) < p_clr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int budget;
        bit exp_alt;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            d_req[i] = 0; d_flags[i] = '0; d_pat[i] = '0; d_key[i] = '0;
        end
        d_ready = 1; d_clr = 0; reset_n = 0;

        // Reset state
        cycle(); cycle();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_key",   bus.out_key, 0);
        reset_n = 1;

        // Tie after reset: alternating grants starting at requester 0
        for (int i = 0; i < 2; i++) begin
            d_req[i] = 1; d_flags[i] = 6'($urandom); d_pat[i] = 4'($urandom); d_key[i] = KEYW'($urandom);
        end
        exp_alt = 0; grants = 0;
        for (int c = 0; c < 12; c++) begin
            cycle();
            chk("tie_one_ack", 32'(bus.ack0 & bus.ack1), 0);
            if (bus.ack0 || bus.ack1) begin
                chk("tie_order", bus.ack1, exp_alt);
                exp_alt = !exp_alt;
                grants++;
            end
            rand_inputs(100, 100, 0);
        end
        chk("tie_count", grants, 4);

        // Single request, quality 15
        d_req[1] = 0; d_req[0] = 1; d_flags[0] = 6'b011111; d_pat[0] = 4'd10; d_key[0] = 8'h5A;
        d_ready = 1;
        cycle();
        chk("single_ack0", bus.ack0, 1);
        chk("single_novalid", bus.out_valid, 0);
        d_req[0] = 0;
        cycle();
        chk("single_valid", bus.out_valid, 1);
        chk("single_q", bus.out_q, 15);
        chk("single_key", bus.out_key, 8'h5A);
        chk("single_src", bus.out_src, 0);
        cycle();
        chk("single_idle", bus.busy, 0);

        // Backpressure with a competing request pending through HOLD
        d_req[1] = 1; d_flags[1] = 6'($urandom); d_pat[1] = 4'($urandom); d_key[1] = KEYW'($urandom);
        d_ready = 0;
        cycle();
        chk("bp_ack1", bus.ack1, 1);
        d_req[1] = 0; d_req[0] = 1; d_flags[0] = 6'($urandom); d_pat[0] = 4'($urandom); d_key[0] = KEYW'($urandom);
        cycle();
        for (int c = 0; c < 10; c++) begin
            cycle();
            chk("bp_noack", bus.ack0, 0);
            chk("bp_valid", bus.out_valid, 1);
        end
        d_ready = 1;
        cycle();
        chk("bp_idle", bus.busy, 0);
        cycle();
        chk("bp_grant", bus.ack0, 1);
        d_req[0] = 0;
        cycle(); cycle(); cycle();

        // Reset while in EVAL
        d_req[0] = 1; d_key[0] = 8'hC3; d_flags[0] = 6'b010101;
        cycle();
        chk("mid_ack0", bus.ack0, 1);
        reset_n = 0; d_req[0] = 0;
        cycle();
        chk("mid_valid", bus.out_valid, 0);
        chk("mid_key", bus.out_key, 0);
        chk("mid_flags", bus.enc_flags, 0);
        chk("mid_busy", bus.busy, 0);
        reset_n = 1;
        cycle();
        chk("mid_novalid", bus.out_valid, 0);
        d_req[0] = 1; d_req[1] = 1;
        cycle();
        chk("mid_tie_ack0", bus.ack0, 1);
        d_req[0] = 0; d_req[1] = 0;
        cycle(); cycle(); cycle();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            rand_inputs(40, 60, 2);
            cycle();
        end

        // Error counter: 300 quality-0 candidates
        d_req[0] = 0; d_req[1] = 0; d_ready = 1; d_clr = 1;
        cycle(); cycle();
        d_clr = 0;
        chk("err_preclr", bus.err_cnt, 0);
        grants = 0; budget = 0;
        while (grants < 300 && budget < 2000) begin
            if (!(d_req[0] && !m_ack[0])) begin
                d_req[0] = 1; d_flags[0] = 6'd0; d_pat[0] = 4'($urandom); d_key[0] = KEYW'($urandom);
            end
            cycle();
            budget++;
            if (bus.ack0) grants++;
        end
        chk("err_grants", grants, 300);
        d_req[0] = 0;
        cycle(); cycle(); cycle();
`ifdef LCT_QSCHED_ERRCNT_EN
        chk("err_sat", bus.err_cnt, 255);
`else
        chk("err_off", bus.err_cnt, 0);
`endif
        d_clr = 1;
        cycle();
        d_clr = 0;
        chk("err_clr", bus.err_cnt, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
